// File: rtl/sasa_pkg.sv
// Shared constants and types for the SASA CAM search front end.
package sasa_pkg;

  localparam int unsigned SASA_CAM_LEN   = 16;
  localparam int unsigned SASA_KEY_W     = 8;
  localparam int unsigned SASA_INPUT_LEN = 64;
  localparam int unsigned SASA_DRAIN_LEN = 64;

  // Bit 6 set and above the rounding window, so downstream decoders stay quiet.
  localparam logic [8:0] SASA_CNT_IDLE = 9'd448;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DRAIN  = 2'd2
  } sasaState_t;

  typedef logic [SASA_CAM_LEN-1:0] match_vec_t;

endpackage

// File: rtl/sasa_cam_row.sv
// One CAM entry: key register, valid bit (plus care mask with SASA_TCAM_EN) and comparator.
module sasa_cam_row
  import sasa_pkg::*;
#(
  parameter int unsigned KEY_W = SASA_KEY_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             write,
  input  logic [KEY_W-1:0] wrData,
`ifdef SASA_TCAM_EN
  input  logic [KEY_W-1:0] wrMask,
`endif
  input  logic [KEY_W-1:0] query,
  output logic             hit
);

  logic [KEY_W-1:0] key;
  logic             valid;
`ifdef SASA_TCAM_EN
  logic [KEY_W-1:0] mask;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key   <= '0;
      valid <= 1'b0;
`ifdef SASA_TCAM_EN
      mask  <= '1;
`endif
    end else if (clear) begin
      valid <= 1'b0;
    end else if (write) begin
      key   <= wrData;
      valid <= 1'b1;
`ifdef SASA_TCAM_EN
      mask  <= wrMask;
`endif
    end
  end

`ifdef SASA_TCAM_EN
  assign hit = valid && (((key ^ query) & mask) == '0);
`else
  assign hit = valid && (key == query);
`endif

endmodule

// File: rtl/sasa_cam_search.sv
// CAM search feeder: streams one query per slot, then drains zero vectors.
// Optional ternary match enabled by defining SASA_TCAM_EN (adds wr_mask port).
module sasa_cam_search
  import sasa_pkg::*;
#(
  parameter int unsigned CAM_LEN   = SASA_CAM_LEN,
  parameter int unsigned KEY_W     = SASA_KEY_W,
  parameter int unsigned INPUT_LEN = SASA_INPUT_LEN,
  parameter int unsigned DRAIN_LEN = SASA_DRAIN_LEN
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       clear_all,
  input  logic                       wr_en,
  input  logic [$clog2(CAM_LEN)-1:0] wr_addr,
  input  logic [KEY_W-1:0]           wr_data,
`ifdef SASA_TCAM_EN
  input  logic [KEY_W-1:0]           wr_mask,
`endif
  input  logic                       q_valid,
  input  logic [KEY_W-1:0]           q_data,
  output logic                       q_ready,
  output logic [CAM_LEN-1:0]         match_vector,
  output logic                       mv_valid,
  output logic [8:0]                 ctrl_counter,
  output logic                       busy,
  output logic                       done,
  output logic                       err
);

  localparam int unsigned ADDR_W = $clog2(CAM_LEN);
  localparam int unsigned SLOT_W = $clog2(INPUT_LEN + DRAIN_LEN);
  localparam logic [SLOT_W-1:0] LAST_SEARCH = SLOT_W'(INPUT_LEN - 1);
  localparam logic [SLOT_W-1:0] LAST_DRAIN  = SLOT_W'(INPUT_LEN + DRAIN_LEN - 1);

  sasaState_t        state;
  logic [SLOT_W-1:0] slot;
  logic [CAM_LEN-1:0] hits;
  logic              isIdle;

  assign isIdle  = (state == IDLE);
  assign q_ready = (state == SEARCH);
  assign busy    = !isIdle;

  for (genvar i = 0; i < CAM_LEN; i++) begin : gRow
    sasa_cam_row #(
      .KEY_W(KEY_W)
    ) uRow (
      .clk   (clk),
      .reset (reset),
      .clear (isIdle && clear_all),
      .write (isIdle && !clear_all && wr_en && (wr_addr == ADDR_W'(i))),
      .wrData(wr_data),
`ifdef SASA_TCAM_EN
      .wrMask(wr_mask),
`endif
      .query (q_data),
      .hit   (hits[i])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      slot         <= '0;
      match_vector <= '0;
      mv_valid     <= 1'b0;
      ctrl_counter <= SASA_CNT_IDLE;
      done         <= 1'b0;
      err          <= 1'b0;
    end else begin
      if (wr_en && !isIdle) err <= 1'b1;
      case (state)
        IDLE: begin
          if (start) begin
            state <= SEARCH;
            slot  <= '0;
          end
        end
        SEARCH: begin
          // An empty slot is still consumed so the downstream windows stay aligned.
          match_vector <= q_valid ? hits : '0;
          mv_valid     <= q_valid;
          if (!q_valid) err <= 1'b1;
          ctrl_counter <= 9'(slot);
          slot         <= slot + 1'b1;
          if (slot == LAST_SEARCH) state <= DRAIN;
        end
        DRAIN: begin
          match_vector <= '0;
          mv_valid     <= 1'b0;
          if (done) begin
            state        <= IDLE;
            ctrl_counter <= SASA_CNT_IDLE;
            done         <= 1'b0;
          end else begin
            ctrl_counter <= 9'(slot);
            done         <= (slot == LAST_DRAIN);
            slot         <= slot + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
